// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM decode and issue stage with scoreboard and fixed-latency writeback.
// Optional same-edge writeback bypass: define ALU_ISSUE_WB_BYPASS_EN.
module alu_issue_stage #(
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [2:0]  operation,
    output logic        logic_arithmetic,
    output logic        add_sub,
    output logic        issue_valid,
    output logic [4:0]  issue_rd,
    output logic        illegal,
    input  logic [31:0] alu_out,
    input  logic [4:0]  rf_dbg_addr,
    output logic [31:0] rf_dbg_data
);

    localparam int DEPTH = ALU_LAT + 1;

    logic [31:0] rf [32];
    logic [31:0] pending;
    logic [DEPTH-1:0] pipe_v;
    logic [4:0]  pipe_rd [DEPTH];

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_op;
    logic        is_imm;
    logic        legal_op;
    logic        legal_imm;
    logic        legal;
    logic        hazard;
    logic        fire;
    logic        do_issue;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        byp1;
    logic        byp2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] src_a;
    logic [31:0] src_b;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign is_op  = (opcode == 7'b0110011);
    assign is_imm = (opcode == 7'b0010011);

    always_comb begin
        legal_op  = 1'b0;
        legal_imm = 1'b0;
        if (is_op) begin
            legal_op = (funct7 == 7'b0000000) ||
                       ((funct7 == 7'b0100000) &&
                        ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end
        if (is_imm) begin
            unique case (funct3)
                3'b001:  legal_imm = (funct7 == 7'b0000000);
                3'b101:  legal_imm = (funct7 == 7'b0000000) ||
                                     (funct7 == 7'b0100000);
                default: legal_imm = 1'b1;
            endcase
        end
    end

    assign legal    = legal_op || legal_imm;
    assign wb_valid = pipe_v[ALU_LAT];
    assign wb_rd    = pipe_rd[ALU_LAT];

`ifdef ALU_ISSUE_WB_BYPASS_EN
    assign byp1 = wb_valid && (wb_rd == rs1) && (rs1 != 5'd0);
    assign byp2 = wb_valid && (wb_rd == rs2) && (rs2 != 5'd0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    assign src_a   = byp1 ? alu_out : rs1_val;
    assign src_b   = is_op ? (byp2 ? alu_out : rs2_val)
                           : {{20{instr[31]}}, instr[31:20]};

    assign hazard = (pending[rs1] && !byp1) ||
                    (is_op && pending[rs2] && !byp2) ||
                    pending[rd];

    assign instr_ready = !rst && (!legal || !hazard);
    assign fire        = instr_valid && instr_ready;
    assign do_issue    = fire && legal;

    assign rf_dbg_data = (rf_dbg_addr == 5'd0) ? 32'd0 : rf[rf_dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            operand_a        <= '0;
            operand_b        <= '0;
            operation        <= '0;
            logic_arithmetic <= 1'b0;
            add_sub          <= 1'b0;
            issue_valid      <= 1'b0;
            issue_rd         <= '0;
            illegal          <= 1'b0;
        end else begin
            issue_valid <= do_issue;
            illegal     <= fire && !legal;
            if (do_issue) begin
                operand_a        <= src_a;
                operand_b        <= src_b;
                operation        <= funct3;
                logic_arithmetic <= (funct3 == 3'b101) && instr[30];
                add_sub          <= is_op && (funct3 == 3'b000) && funct7[5];
                issue_rd         <= rd;
            end
        end
    end

    // Clear before set so a coinciding issue to the same rd keeps it pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            pipe_v  <= '0;
            for (int i = 0; i < DEPTH; i++) pipe_rd[i] <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            pipe_v[0]  <= do_issue;
            pipe_rd[0] <= rd;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_rd[i] <= pipe_rd[i-1];
            end
            if (wb_valid) begin
                pending[wb_rd] <= 1'b0;
                if (wb_rd != 5'd0) rf[wb_rd] <= alu_out;
            end
            if (do_issue && (rd != 5'd0)) pending[rd] <= 1'b1;
        end
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage directly upstream of the registered ALU stage. It accepts RV32I OP and OP-IMM instructions over a valid/ready handshake, reads operands from an internal 32x32 register file and drives the ALU control fields (`operand_a`, `operand_b`, `operation`, `logic_arithmetic`, `add_sub`) from registers. It also captures `alu_out` at a fixed latency to write back `rd`. A per-register scoreboard stalls dependent instructions until their source is written back.

## Interface
Parameters:
- `ALU_LAT`, 2: clock edges after the issue edge at which `alu_out` first carries that instruction's result.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset. Single clock domain.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  32  RV32I instruction word; held stable while `instr_valid && !instr_ready`.
- `instr_ready`  out  1  combinational; instruction consumed at this edge.
- `operand_a`  out  32  registered rs1 value.
- `operand_b`  out  32  registered rs2 value or sign-extended I-immediate.
- `operation`  out  3  registered funct3.
- `logic_arithmetic`  out  1  registered; 1 only for SRA/SRAI.
- `add_sub`  out  1  registered; 1 only for SUB.
- `issue_valid`  out  1  registered; the fields above belong to a new instruction.
- `issue_rd`  out  5  registered destination register of the issued instruction.
- `illegal`  out  1  registered one-cycle pulse; an unsupported instruction was consumed.
- `alu_out`  in  32  result from the downstream ALU stage.
- `rf_dbg_addr`  in  5  debug read address.
- `rf_dbg_data`  out  32  combinational register-file read; x0 reads 0.

## Operation
- Legal encodings:
  - OP (0110011) with funct7 = 0000000, or funct7 = 0100000 with funct3 ∈ {000, 101}.
  - OP-IMM (0010011). For funct3 = 001, imm[11:5] = 0. For funct3 = 101, imm[11:5] ∈ {0000000, 0100000}.
  - Everything else is illegal: consumed with `instr_ready` = 1, `illegal` pulses for one cycle, no issue.
- Field mapping:
  - `operation` = funct3.
  - `add_sub` = OP && funct3 = 000 && funct7[5].
  - `logic_arithmetic` = funct3 = 101 && instr[30].
  - `operand_b` = rs2 value (OP) or sext(instr[31:20]) (OP-IMM).
- Scoreboard: 32 pending bits; x0 is never pending.
- Hazard: any of the following is pending (minus the bypass exception below):
  - rs1;
  - rs2 (OP only);
  - rd (rd ≠ 0; WAW).
- Issue: at the edge where `instr_valid && instr_ready` holds for a legal instruction:
  - output registers load the decoded fields;
  - `issue_valid` = 1;
  - pending[rd] is set if rd ≠ 0.
- Writeback pipe: shift register of {valid, rd}, depth `ALU_LAT`+1. At edge issue+`ALU_LAT`+1 the block samples `alu_out`, writes rf[rd] and clears pending[rd].
  - Writes to x0 are discarded.
  - If set and clear of the same rd coincide on one edge, set wins.
- Non-issue cycles: `issue_valid` = 0; other output fields hold their previous values.
- `instr_ready` = !rst && (illegal || !hazard).

## Timing
- Reset at an edge:
  - all outputs go to 0;
  - the register file clears to 0;
  - pending bits and the writeback pipe clear, so in-flight results are dropped.
- `instr_ready` is 0 while `rst` is high.
- Issue latency: handshake edge E0 → fields valid E0..E1 → `alu_out` valid after E2 → sampled and written at E3 (`ALU_LAT` = 2).
- Dependent spacing (RAW), handshake-to-handshake:
  - 3 cycles with bypass (dependent handshake at E3);
  - 4 cycles without (E4).
- Independent instructions issue every cycle. Throughput is 1/cycle.
- `illegal` follows the consuming edge by one cycle and lasts exactly one cycle.

## Configuration
- `ALU_ISSUE_WB_BYPASS_EN` defined:
  - at the writeback edge, a source whose pending bit clears on that same edge is not a hazard;
  - the operand is taken from `alu_out` instead of the register file.
- Undefined: hazard uses the pending bits only; operands always come from the register file, one cycle after write.

## Test plan
- Reset: pulse `rst`, then read all 32 `rf_dbg_addr` values → all 0. `issue_valid` = 0, `illegal` = 0, `instr_ready` = 1 with a valid ADD offered.
- ADDI x1,x0,5 (0x00500093), bench ALU model returns a+b:
  - next cycle: `issue_valid` = 1, `operand_a` = 0, `operand_b` = 5, `operation` = 000, `add_sub` = 0, `issue_rd` = 1;
  - `rf_dbg_data`[x1] = 5 after E3.
- ADDI x1,x0,5 then ADD x2,x1,x1 (0x00108133) back-to-back:
  - `instr_ready` low for 2 cycles (bypass) or 3 (no bypass);
  - ADD issues with `operand_a` = `operand_b` = 5; x2 = 10.
- SUB x3,x2,x1 (0x401101B3) → `add_sub` = 1. SRAI x4,x1,3 (0x4030D213) → `logic_arithmetic` = 1, `operation` = 101, `operand_b` = 0x00000403.
- ECALL (0x00000073) → consumed in one cycle, `illegal` high exactly one cycle, `issue_valid` stays 0, no register changes.
- ADDI x5,x0,7 issued, `rst` asserted on the following edge → x5 reads 0 afterwards. A subsequent ADD x6,x5,x5 issues without stall with operands 0.
